// File: rtl/quad_gate_tester_pkg.sv
// Shared constants for the quad 2-input AND chip tester: FSM encoding,
// chip pin-to-bit mapping and the per-step stimulus/expected-response rules.
package quad_gate_tester_pkg;

  localparam int NUM_STEPS = 16;
  localparam int NUM_GATES = 4;
  localparam int STIM_W    = 2 * NUM_GATES;
  localparam int STEP_W    = 4;
  localparam int ERR_W     = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRIVE  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam logic [STEP_W-1:0] LAST_STEP = 4'(NUM_STEPS - 1);

  // o_stim bit positions: x goes to the lower pin number of each pair.
  // gate0 pins 1,2 / gate1 pins 4,5 / gate2 pins 9,10 / gate3 pins 12,13
  localparam logic [NUM_GATES-1:0][2:0] GATE_X_BIT = {3'd6, 3'd4, 3'd2, 3'd0};
  localparam logic [NUM_GATES-1:0][2:0] GATE_Y_BIT = {3'd7, 3'd5, 3'd3, 3'd1};

  typedef struct packed {
    logic x;
    logic y;
  } gate_in_t;

  function automatic gate_in_t gate_in(input logic [STEP_W-1:0] s, input int g);
    gate_in_t gi;
    gi.x = s[g];
    gi.y = s[(g + 1) % NUM_GATES];
    return gi;
  endfunction

  function automatic logic [STIM_W-1:0] stim_for_step(input logic [STEP_W-1:0] s);
    logic [STIM_W-1:0] st;
    gate_in_t          gi;
    st = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      gi = gate_in(s, g);
      st[GATE_X_BIT[g]] = gi.x;
      st[GATE_Y_BIT[g]] = gi.y;
    end
    return st;
  endfunction

  function automatic logic [NUM_GATES-1:0] exp_for_step(input logic [STEP_W-1:0] s);
    logic [NUM_GATES-1:0] e;
    gate_in_t             gi;
    e = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      gi   = gate_in(s, g);
      e[g] = gi.x & gi.y;
    end
    return e;
  endfunction

endpackage

// File: rtl/quad_gate_tester_settle_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)               cnt <= '0;
    else if (i_load)           cnt <= i_load_val;
    else if (i_en && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign o_tc = (cnt == '0);

endmodule

// File: rtl/quad_gate_tester.sv
// Exhaustive 16-step functional test of a quad 2-input AND chip: drive each
// step for SETTLE_CYCLES cycles, sample once, accumulate per-gate failures.
module quad_gate_tester
  import quad_gate_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [STIM_W-1:0]    o_stim,
  input  logic [NUM_GATES-1:0] i_resp,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [NUM_GATES-1:0] o_fail_gate,
  output logic [ERR_W-1:0]     o_err_count,
  output logic [STEP_W-1:0]    o_step
);

  state_t               state;
  logic                 start_ok;
  logic                 tmr_load;
  logic                 tmr_tc;
  logic [NUM_GATES-1:0] exp_resp;
  logic [NUM_GATES-1:0] mism;

  assign start_ok = i_start && (state == ST_IDLE || state == ST_DONE);
  // Reload on entry to every DRIVE so it lasts exactly SETTLE_CYCLES cycles.
  assign tmr_load = start_ok || (state == ST_SAMPLE && o_step != LAST_STEP);

  settle_timer #(.W(STEP_W)) u_settle (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tmr_load),
    .i_load_val (4'(SETTLE_CYCLES - 1)),
    .i_en       (state == ST_DRIVE),
    .o_tc       (tmr_tc)
  );

  assign exp_resp = exp_for_step(o_step);

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_cmp
    assign mism[g] = i_resp[g] ^ exp_resp[g];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      o_fail_gate <= '0;
      o_err_count <= '0;
      o_step      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            o_fail_gate <= '0;
            o_err_count <= '0;
            o_step      <= '0;
            state       <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (tmr_tc) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          o_fail_gate <= o_fail_gate | mism;
          if (|mism) o_err_count <= o_err_count + 1'b1;
          if (o_step != LAST_STEP) begin
            o_step <= o_step + 1'b1;
            state  <= ST_DRIVE;
          end else begin
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign o_done = (state == ST_DONE);
  assign o_pass = o_done && (o_err_count == '0);
  assign o_stim = o_busy ? stim_for_step(o_step) : '0;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Directed bench: behavioural quad AND chip with stuck-at injection, plus
// hand-computed expectations for latency, counters and stimulus patterns.
module tb_quad_gate_tester;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] o_stim;
  logic [3:0] i_resp;
  logic       o_busy, o_done, o_pass;
  logic [3:0] o_fail_gate;
  logic [4:0] o_err_count;
  logic [3:0] o_step;

  logic [3:0] stuck1, stuck0;
  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 i_clk = ~i_clk;

  quad_gate_tester #(.SETTLE_CYCLES(2)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .o_stim      (o_stim),
    .i_resp      (i_resp),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_fail_gate (o_fail_gate),
    .o_err_count (o_err_count),
    .o_step      (o_step)
  );

  // Chip model by pin: 3=1&2, 6=4&5, 8=9&10, 11=12&13.
  logic [3:0] ideal;
  always_comb begin
    ideal[0] = o_stim[0] & o_stim[1];
    ideal[1] = o_stim[2] & o_stim[3];
    ideal[2] = o_stim[4] & o_stim[5];
    ideal[3] = o_stim[6] & o_stim[7];
    i_resp   = (ideal | stuck1) & ~stuck0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!o_done && cycles < 200) begin
      tick();
      cycles++;
    end
    if (!o_done) chk("done_timeout", 32'(cycles), 32'd0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_stim"}, 32'(o_stim), 32'd0);
    chk({pfx, "_busy"}, 32'(o_busy), 32'd0);
    chk({pfx, "_done"}, 32'(o_done), 32'd0);
    chk({pfx, "_pass"}, 32'(o_pass), 32'd0);
    chk({pfx, "_fail"}, 32'(o_fail_gate), 32'd0);
    chk({pfx, "_err"},  32'(o_err_count), 32'd0);
    chk({pfx, "_step"}, 32'(o_step), 32'd0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    stuck1  = 4'b0000;
    stuck0  = 4'b0000;
    tick(2);
    i_reset = 1'b0;
    chk_reset_vals("rst");

    // Golden chip: 16 steps x 3 cycles from first DRIVE cycle to DONE.
    pulse_start();
    chk("gold_busy", 32'(o_busy), 32'd1);
    chk("gold_step0_stim", 32'(o_stim), 32'd0);
    wait_done(cnt);
    chk("gold_latency", 32'(cnt), 32'd48);
    chk("gold_pass", 32'(o_pass), 32'd1);
    chk("gold_err", 32'(o_err_count), 32'd0);
    chk("gold_fail", 32'(o_fail_gate), 32'd0);
    chk("gold_done_stim", 32'(o_stim), 32'd0);
    chk("gold_done_busy", 32'(o_busy), 32'd0);
    chk("gold_step_hold", 32'(o_step), 32'd15);
    tick(3);
    chk("gold_done_held", 32'(o_done), 32'd1);

    // Gate 2 stuck at 1: expected 1 only for s=12..15 -> 12 bad steps.
    stuck1 = 4'b0100;
    pulse_start();
    wait_done(cnt);
    chk("s1g2_err", 32'(o_err_count), 32'd12);
    chk("s1g2_fail", 32'(o_fail_gate), 32'b0100);
    chk("s1g2_pass", 32'(o_pass), 32'd0);
    stuck1 = 4'b0000;

    // Gate 0 stuck at 0: expected 1 for s=3,7,11,15 -> 4 bad steps.
    stuck0 = 4'b0001;
    pulse_start();
    tick(9);
    chk("s0g0_step3", 32'(o_step), 32'd3);
    // s=0011: pins 1,2,4 high, and gate 3 wraps to s[0] so pin 13 too.
    chk("s0g0_stim3", 32'(o_stim), 32'b1000_0111);
    tick();
    chk("s0g0_stim3_hold", 32'(o_stim), 32'b1000_0111);
    chk("mid_pass_low", 32'(o_pass), 32'd0);
    wait_done(cnt);
    chk("s0g0_err", 32'(o_err_count), 32'd4);
    chk("s0g0_fail", 32'(o_fail_gate), 32'b0001);
    chk("s0g0_pass", 32'(o_pass), 32'd0);
    stuck0 = 4'b0000;

    // Reset during step 7 after 7 failing samples.
    stuck1 = 4'b0100;
    pulse_start();
    tick(21);
    chk("mr_step7", 32'(o_step), 32'd7);
    chk("mr_err7", 32'(o_err_count), 32'd7);
    i_reset = 1'b1;
    i_start = 1'b1;
    tick();
    i_reset = 1'b0;
    i_start = 1'b0;
    chk_reset_vals("mr");
    tick();
    chk("mr_idle_stays", 32'(o_busy), 32'd0);
    stuck1 = 4'b0000;
    pulse_start();
    wait_done(cnt);
    chk("mr_rerun_latency", 32'(cnt), 32'd48);
    chk("mr_rerun_pass", 32'(o_pass), 32'd1);
    chk("mr_rerun_err", 32'(o_err_count), 32'd0);

    // Start pulse in DRIVE at step 5 is ignored; start in DONE restarts.
    stuck1 = 4'b0100;
    pulse_start();
    tick(15);
    chk("ign_step5", 32'(o_step), 32'd5);
    pulse_start();
    tick(2);
    chk("ign_step6", 32'(o_step), 32'd6);
    tick(3);
    chk("ign_step7", 32'(o_step), 32'd7);
    wait_done(cnt);
    chk("ign_total_latency", 32'(21 + cnt), 32'd48);
    chk("ign_err", 32'(o_err_count), 32'd12);
    stuck1 = 4'b0000;
    pulse_start();
    chk("rs_err_clr", 32'(o_err_count), 32'd0);
    chk("rs_fail_clr", 32'(o_fail_gate), 32'd0);
    chk("rs_step0", 32'(o_step), 32'd0);
    chk("rs_busy", 32'(o_busy), 32'd1);
    chk("rs_done_low", 32'(o_done), 32'd0);
    wait_done(cnt);
    chk("rs_latency", 32'(cnt), 32'd48);
    chk("rs_pass", 32'(o_pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
